// File: rtl/rgb565_gray_expand_ci_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb565_gray_expand_ci_pkg
//  Description : Opcode and FSM state encodings for the gray->RGB565 CI.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb565_gray_expand_ci_pkg;

    localparam int         c_OP_W    = 2;
    localparam logic [1:0] c_OP_LOAD   = 2'd0;
    localparam logic [1:0] c_OP_READ   = 2'd1;
    localparam logic [1:0] c_OP_DIRECT = 2'd2;
    localparam logic [1:0] c_OP_STATUS = 2'd3;

    localparam int         c_STATE_W  = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PIX0  = 2'd1;
    localparam logic [1:0] c_ST_PIX1  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rgb565_gray_expand_ci_gray8_to_rgb565.sv
`default_nettype none
// ============================================================================
//  Module      : gray8_to_rgb565
//  Description : Combinational 8-bit gray to RGB565 expansion (truncating).
//  Revision    : 1.0 - initial release
// ============================================================================
module gray8_to_rgb565 (
    input  logic [7:0]  i_gray,
    output logic [15:0] o_rgb
);

    assign o_rgb = {i_gray[7:3], i_gray[7:2], i_gray[7:3]};

endmodule
`default_nettype wire

// File: rtl/rgb565_gray_expand_ci.sv
`default_nettype none
// ============================================================================
//  Module      : rgb565_gray_expand_ci
//  Description : Multi-cycle CI that expands buffered gray pixels to RGB565.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb565_gray_expand_ci
    import rgb565_gray_expand_ci_pkg::*;
#(
    parameter logic [7:0] CUSTOM_INSTRUCTION_ID = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    input  logic [7:0]  ciN,
    output logic        ciDone,
    output logic [31:0] ciResult
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [31:0]          r_buf;
    logic                 r_ptr;
    logic                 r_valid;
    logic [15:0]          r_pix;
    logic [31:0]          r_result;
    logic                 r_done;

    logic                 w_accept;
    logic [c_OP_W-1:0]    w_op;
    logic [7:0]           w_gray;
    logic [15:0]          w_rgb;
    logic                 w_unused_b;

    assign w_op       = ciValueB[1:0];
    assign w_unused_b = ^ciValueB[31:2];
    assign w_accept   = ciStart && (ciN == CUSTOM_INSTRUCTION_ID) && (r_state == c_ST_IDLE);

    // One converter shared by both pixel cycles; PIX1 takes the upper byte.
    assign w_gray = (r_state == c_ST_PIX1) ? r_pix[15:8] : r_pix[7:0];

    gray8_to_rgb565 u_conv (
        .i_gray (w_gray),
        .o_rgb  (w_rgb)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_op == c_OP_LOAD || w_op == c_OP_STATUS)
                        w_next_state = c_ST_DONE;
                    else
                        w_next_state = c_ST_PIX0;
                end
            end
            c_ST_PIX0: w_next_state = c_ST_PIX1;
            c_ST_PIX1: w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_buf    <= 32'h0;
            r_ptr    <= 1'b0;
            r_valid  <= 1'b0;
            r_pix    <= 16'h0;
            r_result <= 32'h0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_next_state == c_ST_DONE);
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            c_OP_LOAD: begin
                                r_buf    <= ciValueA;
                                r_ptr    <= 1'b0;
                                r_valid  <= 1'b1;
                                r_result <= 32'h0;
                            end
                            c_OP_READ: begin
                                // Empty buffer yields a zero pair, which converts to zero.
                                if (r_valid) begin
                                    r_pix <= r_ptr ? r_buf[31:16] : r_buf[15:0];
                                    r_ptr <= ~r_ptr;
                                    if (r_ptr)
                                        r_valid <= 1'b0;
                                end else begin
                                    r_pix <= 16'h0;
                                end
                            end
                            c_OP_DIRECT: r_pix    <= ciValueA[15:0];
                            default:     r_result <= {30'b0, r_ptr, r_valid};
                        endcase
                    end
                end
                c_ST_PIX0: r_result[15:0]  <= w_rgb;
                c_ST_PIX1: r_result[31:16] <= w_rgb;
                c_ST_DONE: r_result        <= 32'h0;
                default:   r_result        <= 32'h0;
            endcase
        end
    end

    assign ciDone   = r_done;
    assign ciResult = r_done ? r_result : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_rgb565_gray_expand_ci.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb565_gray_expand_ci
//  Description : Directed self-checking bench for rgb565_gray_expand_ci.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb565_gray_expand_ci;

    logic        clock;
    logic        reset;
    logic        ciStart;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic [7:0]  ciN;
    logic        ciDone;
    logic [31:0] ciResult;

    int n_assert = 0;
    int n_fail   = 0;

    rgb565_gray_expand_ci #(.CUSTOM_INSTRUCTION_ID(8'd0)) dut (
        .clock    (clock),
        .reset    (reset),
        .ciStart  (ciStart),
        .ciValueA (ciValueA),
        .ciValueB (ciValueB),
        .ciN      (ciN),
        .ciDone   (ciDone),
        .ciResult (ciResult)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_rgb(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one CI, scramble operands after accept, then check latency, value and pulse width.
    task automatic run_ci(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] exp, input int lat);
        int  n;
        logic seen;
        @(negedge clock);
        ciStart  = 1'b1;
        ciN      = 8'd0;
        ciValueA = a;
        ciValueB = {30'h2AAAAAAA, op};
        @(posedge clock);
        #1;
        ciStart  = 1'b0;
        ciValueA = ~a;
        ciValueB = {30'h0, ~op};
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 12) begin
            @(negedge clock);
            n++;
            if (ciDone === 1'b1) seen = 1'b1;
            else check({tag, " idle-result"}, ciResult, 32'h0);
        end
        check({tag, " latency"}, n, lat);
        check({tag, " result"}, ciResult, exp);
        @(negedge clock);
        check({tag, " pulse-width"}, {31'b0, ciDone}, 32'h0);
        check({tag, " post-result"}, ciResult, 32'h0);
    endtask

    // Watch a number of cycles, counting done pulses and checking zero result outside them.
    task automatic watch(input string tag, input int cycles, output int dones, output logic [31:0] last);
        dones = 0;
        last  = 32'h0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (ciDone === 1'b1) begin
                dones++;
                last = ciResult;
            end else begin
                check({tag, " gated-result"}, ciResult, 32'h0);
            end
        end
    endtask

    int          dones;
    logic [31:0] last;
    logic [7:0]  g_lo;
    logic [7:0]  g_hi;

    initial begin
        reset    = 1'b1;
        ciStart  = 1'b0;
        ciValueA = 32'h0;
        ciValueB = 32'h0;
        ciN      = 8'd0;
        repeat (3) @(negedge clock);
        check("reset done", {31'b0, ciDone}, 32'h0);
        check("reset result", ciResult, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("post-reset done", {31'b0, ciDone}, 32'h0);
        run_ci("reset status", 2'd3, 32'h0, 32'h0, 1);

        // Test 1: DIRECT
        run_ci("direct 80ff", 2'd2, 32'h0000_80FF, 32'h8410_FFFF, 3);

        // Test 2: LOAD and drain
        run_ci("load a", 2'd0, 32'h00FF_8000, 32'h0, 1);
        run_ci("read p0", 2'd1, 32'h0, 32'h8410_0000, 3);
        run_ci("read p1", 2'd1, 32'h0, 32'h0000_FFFF, 3);
        run_ci("read empty", 2'd1, 32'h0, 32'h0, 3);
        run_ci("status empty", 2'd3, 32'h0, 32'h0, 1);

        // Test 3: status after partial drain and reload
        run_ci("load b", 2'd0, 32'h1234_5678, 32'h0, 1);
        run_ci("read b p0", 2'd1, 32'h0, 32'h52AA_7BCF, 3);
        run_ci("status half", 2'd3, 32'h0, 32'h3, 1);
        run_ci("reload", 2'd0, 32'h0, 32'h0, 1);
        run_ci("status reload", 2'd3, 32'h0, 32'h1, 1);
        run_ci("read zero p0", 2'd1, 32'hFFFF_FFFF, 32'h0, 3);
        run_ci("read zero p1", 2'd1, 32'hFFFF_FFFF, 32'h0, 3);
        run_ci("status drained", 2'd3, 32'h0, 32'h0, 1);

        // Test 4: wrong id, and a start while busy
        @(negedge clock);
        ciStart  = 1'b1;
        ciN      = 8'h05;
        ciValueA = 32'h0000_FFFF;
        ciValueB = 32'h2;
        @(negedge clock);
        ciStart = 1'b0;
        ciN     = 8'd0;
        watch("wrong id", 6, dones, last);
        check("wrong id dones", dones, 0);

        @(negedge clock);
        ciStart  = 1'b1;
        ciValueA = 32'h0000_7878;
        ciValueB = 32'h2;
        @(posedge clock);
        #1;
        ciValueA = 32'h0;
        ciValueB = 32'h3;
        @(negedge clock);
        ciStart = 1'b0;
        watch("busy start", 8, dones, last);
        check("busy start dones", dones, 1);
        check("busy start value", last, 32'h7BCF_7BCF);

        // Test 5: reset during PIX1 of a READ
        run_ci("load c", 2'd0, 32'h00FF_8000, 32'h0, 1);
        @(negedge clock);
        ciStart  = 1'b1;
        ciValueB = 32'h1;
        @(posedge clock);
        #1;
        ciStart = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        watch("abort", 6, dones, last);
        check("abort dones", dones, 0);
        run_ci("status after abort", 2'd3, 32'h0, 32'h0, 1);
        run_ci("read after abort", 2'd1, 32'h0, 32'h0, 3);

        // Test 6: directed corners and full sweep through DIRECT
        run_ci("direct 7878", 2'd2, 32'h0000_7878, 32'h7BCF_7BCF, 3);
        run_ci("direct 0000", 2'd2, 32'h0000_0000, 32'h0, 3);
        for (int g = 0; g < 256; g += 2) begin
            g_lo = 8'(g);
            g_hi = 8'(g + 1);
            run_ci("sweep", 2'd2, {16'hA5A5, g_hi, g_lo}, {ref_rgb(g_hi), ref_rgb(g_lo)}, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
